// File: rtl/mux_rr_reg_if.sv
// Handshake bundle for mux_rr_reg: N_IN valid/ready input channels, mode/select
// control and one registered valid/ready output channel.
interface mux_rr_reg_if #(
   parameter int WIDTH = 8,
   parameter int N_IN  = 4
);
   localparam int SEL_W = $clog2(N_IN);

   logic [N_IN*WIDTH-1:0] in_data;
   logic [N_IN-1:0]       in_valid;
   logic [N_IN-1:0]       in_ready;
   logic                  mode;
   logic [SEL_W-1:0]      sel;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [SEL_W-1:0]      out_ch;

   // master drives the channels and consumes the output; slave is the mux itself
   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_valid, out_ch
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_valid, out_ch
   );
endinterface

// File: rtl/mux_rr_reg.sv
// N:1 registered mux with fixed-select or round-robin grant and a single-entry output register.
// Optional MUX_RR_XFER_CNT_EN adds a saturating 16-bit output-transfer counter port xfer_cnt.
module mux_rr_reg #(
   parameter int WIDTH = 8,
   parameter int N_IN  = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mux_rr_reg_if.slave   bus
`ifdef MUX_RR_XFER_CNT_EN
   ,
   output logic [15:0]   xfer_cnt
`endif
);
   localparam int SEL_W = $clog2(N_IN);

   logic [WIDTH-1:0] data_p1;
   logic [SEL_W-1:0] ch_p1;
   logic             vld_p1;
   logic [SEL_W-1:0] ptr;

   logic             load_en;
   logic             grant_vld;
   logic [SEL_W-1:0] grant;
   logic             xfer_in;

   assign load_en = !vld_p1 || bus.out_ready;
   assign xfer_in = load_en && grant_vld;

   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      if (!bus.mode) begin
         if (int'(bus.sel) < N_IN) begin
            if (bus.in_valid[bus.sel]) begin
               grant_vld = 1'b1;
               grant     = bus.sel;
            end
         end
      end else begin
         // scan from the farthest offset down so the channel nearest ptr wins
         for (int i = N_IN - 1; i >= 0; i--) begin
            if (bus.in_valid[(int'(ptr) + i) % N_IN]) begin
               grant_vld = 1'b1;
               grant     = SEL_W'((int'(ptr) + i) % N_IN);
            end
         end
      end
   end

   // ready is gated by rst_n so no channel sees a handshake while in reset
   always_comb begin
      bus.in_ready = '0;
      if (rst_n && xfer_in) begin
         bus.in_ready = N_IN'(1) << grant;
      end
   end

   // output register stage (p1)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         ch_p1   <= '0;
      end else if (load_en) begin
         vld_p1 <= grant_vld;
         if (grant_vld) begin
            data_p1 <= bus.in_data[grant*WIDTH +: WIDTH];
            ch_p1   <= grant;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (xfer_in && bus.mode) begin
         if (int'(grant) == N_IN - 1) begin
            ptr <= '0;
         end else begin
            ptr <= grant + 1'b1;
         end
      end
   end

`ifdef MUX_RR_XFER_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (vld_p1 && bus.out_ready && (xfer_cnt != 16'hFFFF)) begin
         xfer_cnt <= xfer_cnt + 16'd1;
      end
   end
`endif

   assign bus.out_data  = data_p1;
   assign bus.out_ch    = ch_p1;
   assign bus.out_valid = vld_p1;
endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: reset, fixed select, round-robin fairness/skip,
// backpressure, no-grant drain and (with MUX_RR_XFER_CNT_EN) counter saturation.
module tb_mux_rr_reg;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mux_rr_reg_if #(.WIDTH(8), .N_IN(4)) bus ();

`ifdef MUX_RR_XFER_CNT_EN
   logic [15:0] xfer_cnt;
   mux_rr_reg #(.WIDTH(8), .N_IN(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .xfer_cnt (xfer_cnt)
   );
`else
   mux_rr_reg #(.WIDTH(8), .N_IN(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one edge, land 1 time unit after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
      bus.in_data = {d3, d2, d1, d0};
   endtask

   initial begin
      logic [1:0] exp_ch;
      logic [1:0] skip_seq [3];
      checks = 0;
      errors = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 4'b1111;
      bus.mode      = 1'b0;
      bus.sel       = 2'd0;
      bus.out_ready = 1'b1;
      set_data(8'h01, 8'h02, 8'h03, 8'h04);

      // reset state, ready gated even though channels are valid
      #2;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_ch", bus.out_ch, 0);
      chk("rst_in_ready", bus.in_ready, 4'b0000);
      step();
      step();
      rst_n = 1'b1;
      chk("post_rst_empty", bus.out_valid, 0);

      // fixed mode select 2
      bus.sel = 2'd2;
      set_data(8'h10, 8'h11, 8'hA5, 8'h13);
      #1;
      chk("fix_in_ready", bus.in_ready, 4'b0100);
      step();
      chk("fix_out_data", bus.out_data, 8'hA5);
      chk("fix_out_ch", bus.out_ch, 2);
      chk("fix_out_valid", bus.out_valid, 1);

      // round-robin fairness; ptr still 0 after fixed-mode transfer
      bus.mode = 1'b1;
      set_data(8'h10, 8'h11, 8'h12, 8'h13);
      for (int k = 0; k < 6; k++) begin
         exp_ch = 2'(k % 4);
         #1;
         chk("rr_in_ready", bus.in_ready, 4'b0001 << exp_ch);
         step();
         chk("rr_out_ch", bus.out_ch, exp_ch);
         chk("rr_out_data", bus.out_data, 8'h10 + exp_ch);
         chk("rr_out_valid", bus.out_valid, 1);
      end

      // ptr is 2; a ch0-only transfer moves it to 1
      bus.in_valid = 4'b0001;
      step();
      chk("rr_ch0_only", bus.out_ch, 0);

      // skip: ptr=1, only ch0/ch3 valid -> 3, 0, 3
      bus.in_valid = 4'b1001;
      skip_seq[0] = 2'd3;
      skip_seq[1] = 2'd0;
      skip_seq[2] = 2'd3;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("skip_in_ready", bus.in_ready, 4'b0001 << skip_seq[k]);
         step();
         chk("skip_out_ch", bus.out_ch, skip_seq[k]);
         chk("skip_out_data", bus.out_data, 8'h10 + skip_seq[k]);
      end

      // backpressure: ch3 beat (13) held while inputs change
      bus.out_ready = 1'b0;
      bus.in_valid  = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         set_data(8'h20 + 8'(k), 8'h30 + 8'(k), 8'h40 + 8'(k), 8'h50 + 8'(k));
         #1;
         chk("bp_in_ready", bus.in_ready, 4'b0000);
         step();
         chk("bp_out_data", bus.out_data, 8'h13);
         chk("bp_out_ch", bus.out_ch, 3);
         chk("bp_out_valid", bus.out_valid, 1);
      end
      // release: drain and load same edge (ptr=0, only ch2 valid)
      bus.out_ready = 1'b1;
      bus.in_valid  = 4'b0100;
      set_data(8'h00, 8'h00, 8'h5A, 8'h00);
      #1;
      chk("bp_rel_in_ready", bus.in_ready, 4'b0100);
      step();
      chk("bp_rel_out_data", bus.out_data, 8'h5A);
      chk("bp_rel_out_ch", bus.out_ch, 2);
      chk("bp_rel_out_valid", bus.out_valid, 1);

      // no grant: sel=2 with ch2 idle, output drains to empty
      bus.mode     = 1'b0;
      bus.sel      = 2'd2;
      bus.in_valid = 4'b1011;
      #1;
      chk("nogrant_in_ready", bus.in_ready, 4'b0000);
      step();
      chk("nogrant_out_valid", bus.out_valid, 0);
      step();
      chk("nogrant_still_empty", bus.out_valid, 0);

      // ptr held at 3 through fixed-mode cycles
      bus.mode     = 1'b1;
      bus.in_valid = 4'b1111;
      set_data(8'h60, 8'h61, 8'h62, 8'h63);
      #1;
      chk("ptr_hold_in_ready", bus.in_ready, 4'b1000);
      step();
      chk("ptr_hold_out_ch", bus.out_ch, 3);
      chk("ptr_hold_out_data", bus.out_data, 8'h63);

      // asynchronous reset mid-beat
      bus.out_ready = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_out_data", bus.out_data, 0);
      chk("arst_out_ch", bus.out_ch, 0);
      chk("arst_in_ready", bus.in_ready, 4'b0000);
      bus.out_ready = 1'b1;
      step();
      rst_n = 1'b1;
      #1;
      chk("arst_ptr_zero", bus.in_ready, 4'b0001);

`ifdef MUX_RR_XFER_CNT_EN
      chk("cnt_after_rst", xfer_cnt, 0);
      for (int k = 0; k < 70000; k++) begin
         step();
      end
      chk("cnt_saturate", xfer_cnt, 16'hFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
Parametrised N:1 registered multiplexer with valid/ready handshakes on every input channel and on the output. It is the sequential successor to the 2:1 combinational MUX in the ALU datapath. It selects one channel per cycle, either by an explicit SEL (fixed mode) or by a round-robin arbiter (RR mode), and holds the result in a single-entry output register with backpressure. It sits between ALU operand sources and the ALU operand input.

Parameters:
WIDTH, 8, data width per channel in bits (>=1)
N_IN, 4, number of input channels (>=2); SEL_W = $clog2(N_IN) is a derived localparam

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
IN_DATA  input  N_IN*WIDTH  packed channel data; channel i at [i*WIDTH +: WIDTH]
IN_VALID  input  N_IN  per-channel valid
IN_READY  output  N_IN  per-channel ready; at most one bit high per cycle
MODE  input  1  0 = fixed select via SEL, 1 = round-robin
SEL  input  SEL_W  channel select, used only when MODE=0
OUT_DATA  output  WIDTH  registered selected data
OUT_VALID  output  1  OUT_DATA/OUT_CH hold a valid beat
OUT_READY  input  1  downstream accepts the beat
OUT_CH  output  SEL_W  channel index that produced OUT_DATA

Behaviour:
- Reset (RST_N=0, asynchronous): OUT_VALID=0, OUT_DATA=0, OUT_CH=0, round-robin pointer PTR=0. IN_READY is all 0 while RST_N=0.
- Reset mid-operation: a held beat is discarded. No transfer occurs on the release edge unless the handshake is valid that cycle.
- Output register states:
  - EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
  - load_en = !OUT_VALID | OUT_READY.
- Grant (combinational, depends on current-cycle inputs plus PTR):
  - MODE=0: grant SEL if SEL < N_IN and IN_VALID[SEL]=1; otherwise no grant. An out-of-range SEL never grants.
  - MODE=1: search channels starting at PTR and ascending with wrap at N_IN-1 -> 0. The first channel with IN_VALID=1 is granted.
- IN_READY[g] = load_en & grant_valid, one-hot at g; all other bits are 0. IN_READY may depend combinationally on IN_VALID, MODE, SEL and OUT_READY.
- Transfer at a clock edge when load_en & grant_valid: OUT_DATA <= channel g data, OUT_CH <= g, OUT_VALID <= 1. Latency is 1 cycle input-to-output.
- Throughput: 1 beat/cycle when OUT_READY is held at 1.
- load_en with no grant: OUT_VALID <= 0. OUT_DATA and OUT_CH keep their last values (don't-care).
- Stall (OUT_VALID=1, OUT_READY=0): OUT_DATA, OUT_CH and OUT_VALID stay stable; IN_READY is all 0.
- PTR updates only on an RR-mode transfer: PTR <= (g == N_IN-1) ? 0 : g+1.
  - PTR holds in MODE=0 and on cycles without a transfer.
  - A MODE change takes effect in the same cycle's grant; PTR is not reset by a mode change.
- Simultaneous drain and load (FULL, OUT_READY=1, grant valid): the old beat leaves and the new beat is written in the same edge; OUT_VALID stays 1.
- Input data need not stay stable after a channel's valid drops. Channels obey standard valid/ready: a channel must hold data while IN_VALID=1 and it is not yet granted.

Optional Feature:
MUX_RR_XFER_CNT_EN
- Defined: adds output port XFER_CNT (16 bits).
  - Counts output transfers (OUT_VALID & OUT_READY).
  - Saturates at 16'hFFFF.
  - Reset value 0 (async with RST_N).
- Undefined: the port and counter logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert RST_N=0 mid-beat while OUT_VALID=1 -> OUT_VALID=0, OUT_DATA=0, OUT_CH=0 immediately, without waiting for a clock edge; IN_READY=4'b0000.
- Fixed mode: MODE=0, SEL=2, IN_VALID=4'b1111, IN_DATA ch2=8'hA5, OUT_READY=1 -> IN_READY=4'b0100; the next cycle has OUT_DATA=8'hA5, OUT_CH=2, OUT_VALID=1.
- Round-robin fairness: MODE=1, all valid, ch0..3 data = 8'h10, 8'h11, 8'h12, 8'h13, OUT_READY=1 for 6 cycles -> OUT_CH sequence 0, 1, 2, 3, 0, 1 and OUT_DATA matches.
- RR skip: MODE=1, PTR=1, IN_VALID=4'b1001 -> ch3 is granted, then ch0, then ch3; channels 1 and 2 are never granted.
- Backpressure: OUT_VALID=1, OUT_READY=0 for 3 cycles while inputs change -> OUT_DATA and OUT_CH stay constant, IN_READY=0. When OUT_READY rises, the held beat drains and a new beat loads on the same edge.
- Edge cases: MODE=0 with SEL=2 and IN_VALID=4'b1011 -> no grant, OUT_VALID falls to 0 after draining. With MUX_RR_XFER_CNT_EN defined, 70000 consecutive transfers -> XFER_CNT=16'hFFFF.
